// File: rtl/clkdiv_pkg.sv
// Shared constants for the programmable backscatter clock divider.
package clkdiv_pkg;
    localparam int unsigned CLKDIV_CNT_W        = 8;
    localparam int unsigned CLKDIV_DEFAULT_HALF = 1;
    localparam int unsigned CLKDIV_HALF_MIN     = 0;
    localparam int unsigned CLKDIV_HALF_MAX     = (1 << CLKDIV_CNT_W) - 1;
endpackage

// File: rtl/clock_divider_prog_if.sv
// Control/status bundle of clock_divider_prog; master = firmware side, slave = divider.
interface clock_divider_prog_if #(
    parameter int unsigned CNT_W = clkdiv_pkg::CLKDIV_CNT_W
);
    logic             enable;
    logic [CNT_W-1:0] half_period;
    logic             load;
    logic             sync;
    logic             clock_out;
    logic             tick;
    logic             update_pending;

    modport master (
        output enable, half_period, load, sync,
        input  clock_out, tick, update_pending
    );

    modport slave (
        input  enable, half_period, load, sync,
        output clock_out, tick, update_pending
    );
endinterface

// File: rtl/clkdiv_period_shadow.sv
// Shadow half-period register, pending flag and the mux choosing the value to apply.
import clkdiv_pkg::*;

module clkdiv_period_shadow #(
    parameter int unsigned CNT_W        = CLKDIV_CNT_W,
    parameter int unsigned DEFAULT_HALF = CLKDIV_DEFAULT_HALF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_half_period,
    input  logic             i_apply,
    output logic             o_pend,
    output logic             o_take,
    output logic [CNT_W-1:0] o_new_half
);
    logic [CNT_W-1:0] r_shadow;
    logic             r_pend;

    // A load coinciding with the apply point bypasses the shadow register.
    assign o_new_half = i_load ? i_half_period : r_shadow;
    assign o_take     = i_apply & (i_load | r_pend);
    assign o_pend     = r_pend;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_shadow <= CNT_W'(DEFAULT_HALF);
            r_pend   <= 1'b0;
        end else if (i_apply) begin
            r_pend <= 1'b0;
            if (i_load) r_shadow <= i_half_period;
        end else if (i_load) begin
            r_shadow <= i_half_period;
            r_pend   <= 1'b1;
        end
    end
endmodule

// File: rtl/clock_divider_prog.sv
// Glitch-free programmable 50% clock divider; ratio changes only at a full-period boundary.
// Optional phase realign on sync when CLKDIV_SYNC_EN is defined.
import clkdiv_pkg::*;

module clock_divider_prog #(
    parameter int unsigned CNT_W        = CLKDIV_CNT_W,
    parameter int unsigned DEFAULT_HALF = CLKDIV_DEFAULT_HALF
) (
    input  logic                 clock,
    input  logic                 reset,
    clock_divider_prog_if.slave  bus
);
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_active_half;
    logic             r_clk_out;
    logic             r_tick;
    logic             w_tc;
    logic             w_sync;
    logic             w_apply;
    logic             w_take;
    logic             w_pend;
    logic [CNT_W-1:0] w_new_half;

`ifdef CLKDIV_SYNC_EN
    assign w_sync = bus.sync & bus.enable;
`else
    logic w_unused_sync;
    assign w_unused_sync = bus.sync;
    assign w_sync        = 1'b0;
`endif

    assign w_tc    = (r_cnt == r_active_half);
    // Only the falling edge that closes a period (or a realign) may change the ratio.
    assign w_apply = bus.enable & (w_sync | (w_tc & r_clk_out));

    clkdiv_period_shadow #(
        .CNT_W        (CNT_W),
        .DEFAULT_HALF (DEFAULT_HALF)
    ) u_shadow (
        .clock         (clock),
        .reset         (reset),
        .i_load        (bus.load),
        .i_half_period (bus.half_period),
        .i_apply       (w_apply),
        .o_pend        (w_pend),
        .o_take        (w_take),
        .o_new_half    (w_new_half)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cnt         <= '0;
            r_clk_out     <= 1'b0;
            r_tick        <= 1'b0;
            r_active_half <= CNT_W'(DEFAULT_HALF);
        end else begin
            if (w_take) r_active_half <= w_new_half;
            if (!bus.enable) begin
                r_tick <= 1'b0;
            end else if (w_sync) begin
                r_cnt     <= '0;
                r_clk_out <= 1'b0;
                r_tick    <= 1'b0;
            end else if (w_tc) begin
                r_cnt     <= '0;
                r_clk_out <= ~r_clk_out;
                r_tick    <= 1'b1;
            end else begin
                r_cnt  <= r_cnt + 1'b1;
                r_tick <= 1'b0;
            end
        end
    end

    assign bus.clock_out      = r_clk_out;
    assign bus.tick           = r_tick;
    assign bus.update_pending = w_pend;
endmodule

// File: tb/tb_clock_divider_prog.sv
// Directed bench for clock_divider_prog: reset, load timing, last-write-wins, enable, div-2, sync.
module tb_clock_divider_prog;
    logic clock;
    logic reset;
    int   total;
    int   bad;

    clock_divider_prog_if #(.CNT_W(8)) bus ();

    clock_divider_prog #(.CNT_W(8), .DEFAULT_HALF(1)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        bus.load = 1'b0;
        bus.sync = 1'b0;
        bus.enable = 1'b1;
        bus.half_period = '0;
        step();
        step();
        reset = 1'b1;
    endtask

    // Defaults: divide-by-4, high 2, tick every 2 cycles, low while in reset.
    task automatic test_reset();
        do_reset();
        reset = 1'b0;
        step();
        total++;
        if (bus.clock_out !== 1'b0 || bus.tick !== 1'b0 || bus.update_pending !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: clk=%b tick=%b pend=%b want 0 0 0", bus.clock_out, bus.tick, bus.update_pending);
        end
        reset = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            logic ec, et;
            step();
            ec = (i % 4 == 2) || (i % 4 == 3);
            et = (i % 2 == 0);
            total++;
            if (bus.clock_out !== ec || bus.tick !== et) begin
                bad++;
                $display("FAIL reset_release edge %0d: clk=%b tick=%b want %b %b", i, bus.clock_out, bus.tick, ec, et);
            end
        end
    endtask

    // Continues from cnt=0, clk=0, active=1.
    task automatic test_load();
        step();
        step();
        bus.half_period = 8'd4;
        bus.load = 1'b1;
        step();
        bus.load = 1'b0;
        total++;
        if (bus.update_pending !== 1'b1 || bus.clock_out !== 1'b1) begin
            bad++;
            $display("FAIL load_pending: pend=%b clk=%b want 1 1", bus.update_pending, bus.clock_out);
        end
        step();
        total++;
        if (bus.update_pending !== 1'b0 || bus.clock_out !== 1'b0) begin
            bad++;
            $display("FAIL load_apply: pend=%b clk=%b want 0 0", bus.update_pending, bus.clock_out);
        end
        for (int i = 1; i <= 10; i++) begin
            logic ec, et;
            step();
            ec = (i >= 5 && i < 10);
            et = (i == 5 || i == 10);
            total++;
            if (bus.clock_out !== ec || bus.tick !== et) begin
                bad++;
                $display("FAIL load_div10 cycle %0d: clk=%b tick=%b want %b %b", i, bus.clock_out, bus.tick, ec, et);
            end
        end
    endtask

    // Continues from cnt=0, clk=0, active=4.
    task automatic test_last_wins();
        bus.half_period = 8'd3;
        bus.load = 1'b1;
        step();
        bus.load = 1'b0;
        step();
        bus.half_period = 8'd7;
        bus.load = 1'b1;
        step();
        bus.load = 1'b0;
        bus.half_period = 8'd3;
        total++;
        if (bus.update_pending !== 1'b1) begin
            bad++;
            $display("FAIL last_wins_pending: pend=%b want 1", bus.update_pending);
        end
        for (int i = 0; i < 7; i++) step();
        total++;
        if (bus.update_pending !== 1'b0 || bus.clock_out !== 1'b0) begin
            bad++;
            $display("FAIL last_wins_apply: pend=%b clk=%b want 0 0", bus.update_pending, bus.clock_out);
        end
        for (int i = 1; i <= 16; i++) begin
            logic ec;
            step();
            ec = (i >= 8 && i < 16);
            total++;
            if (bus.clock_out !== ec) begin
                bad++;
                $display("FAIL last_wins_div16 cycle %0d: clk=%b want %b", i, bus.clock_out, ec);
            end
        end
    endtask

    // Freeze at cnt=1 for 5 cycles; a load of 0 is accepted meanwhile.
    task automatic test_enable();
        do_reset();
        step();
        bus.enable = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            bus.load = (i == 3);
            bus.half_period = 8'd0;
            step();
            total++;
            if (bus.clock_out !== 1'b0 || bus.tick !== 1'b0) begin
                bad++;
                $display("FAIL enable_hold cycle %0d: clk=%b tick=%b want 0 0", i, bus.clock_out, bus.tick);
            end
        end
        bus.load = 1'b0;
        total++;
        if (bus.update_pending !== 1'b1) begin
            bad++;
            $display("FAIL enable_load_accepted: pend=%b want 1", bus.update_pending);
        end
        bus.enable = 1'b1;
        step();
        total++;
        if (bus.clock_out !== 1'b1 || bus.tick !== 1'b1) begin
            bad++;
            $display("FAIL enable_resume: clk=%b tick=%b want 1 1", bus.clock_out, bus.tick);
        end
    endtask

    // Pending 0 applies at the end of the current high phase, then divide-by-2.
    task automatic test_div2();
        step();
        total++;
        if (bus.clock_out !== 1'b1 || bus.tick !== 1'b0) begin
            bad++;
            $display("FAIL div2_pre: clk=%b tick=%b want 1 0", bus.clock_out, bus.tick);
        end
        step();
        total++;
        if (bus.clock_out !== 1'b0 || bus.update_pending !== 1'b0) begin
            bad++;
            $display("FAIL div2_apply: clk=%b pend=%b want 0 0", bus.clock_out, bus.update_pending);
        end
        for (int i = 1; i <= 6; i++) begin
            logic ec;
            step();
            ec = (i % 2 == 1);
            total++;
            if (bus.clock_out !== ec || bus.tick !== 1'b1) begin
                bad++;
                $display("FAIL div2_toggle cycle %0d: clk=%b tick=%b want %b 1", i, bus.clock_out, bus.tick, ec);
            end
        end
    endtask

    // Pending 2 queued during the low phase, sync strobed at cnt=0 of the high phase.
    task automatic test_sync();
        do_reset();
        step();
        bus.half_period = 8'd2;
        bus.load = 1'b1;
        step();
        bus.load = 1'b0;
        bus.sync = 1'b1;
        step();
        bus.sync = 1'b0;
`ifdef CLKDIV_SYNC_EN
        total++;
        if (bus.clock_out !== 1'b0 || bus.tick !== 1'b0 || bus.update_pending !== 1'b0) begin
            bad++;
            $display("FAIL sync_realign: clk=%b tick=%b pend=%b want 0 0 0", bus.clock_out, bus.tick, bus.update_pending);
        end
`else
        total++;
        if (bus.clock_out !== 1'b1 || bus.update_pending !== 1'b1) begin
            bad++;
            $display("FAIL sync_ignored: clk=%b pend=%b want 1 1", bus.clock_out, bus.update_pending);
        end
        step();
        total++;
        if (bus.clock_out !== 1'b0 || bus.update_pending !== 1'b0) begin
            bad++;
            $display("FAIL sync_ignored_apply: clk=%b pend=%b want 0 0", bus.clock_out, bus.update_pending);
        end
`endif
        for (int i = 1; i <= 6; i++) begin
            logic ec;
            step();
            ec = (i >= 3 && i < 6);
            total++;
            if (bus.clock_out !== ec) begin
                bad++;
                $display("FAIL sync_div6 cycle %0d: clk=%b want %b", i, bus.clock_out, ec);
            end
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        reset = 1'b0;
        test_reset();
        test_load();
        test_last_wins();
        test_enable();
        test_div2();
        test_sync();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
